perspective_divide_seq: RTL and testbench

//  Upstream sequencer for the shared iterative divider.

---
 rtl/perspective_divide_seq_pkg.sv | 27 ++
 rtl/perspective_divide_seq_if.sv | 52 +++++
 rtl/perspective_divide_seq_sign_mag_split.sv | 25 ++
 rtl/perspective_divide_seq.sv | 167 ++++++++++++++++
 tb/tb_perspective_divide_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perspective_divide_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proj_pkg
// Purpose  : Shared types and default sizing for the perspective-divide
//            sequencer (state encoding, default widths, width sanity flag).
// Revision : 1.0  initial release
// ============================================================================
package proj_pkg;

    localparam int COORD_W_DEF = 16;
    localparam int FRAC_DEF    = 8;
    localparam int WIDTH_DEF   = 32;

    // Shifted magnitude must fit inside the divider operand.
    localparam bit WIDTH_OK = (COORD_W_DEF + FRAC_DEF) <= WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_X = 3'd1,
        WAIT_X  = 3'd2,
        ISSUE_Y = 3'd3,
        WAIT_Y  = 3'd4,
        DONE    = 3'd5
    } proj_state_t;

endpackage
`default_nettype wire

// File: rtl/perspective_divide_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : perspective_divide_seq_if
// Purpose  : Bundles the vertex input handshake, the divider request/response
//            link and the projected-pixel output handshake.
// Ports    : slave  - view taken by the sequencer
//            master - view taken by the surrounding environment
// Revision : 1.0  initial release
// ============================================================================
interface perspective_divide_seq_if #(
    parameter int COORD_W = 16,
    parameter int WIDTH   = 32
);
    logic signed [COORD_W-1:0] vtx_x_in;
    logic signed [COORD_W-1:0] vtx_y_in;
    logic signed [COORD_W-1:0] vtx_z_in;
    logic                      vtx_valid_in;
    logic                      vtx_ready_out;

    logic [WIDTH-1:0]          div_dividend_out;
    logic [WIDTH-1:0]          div_divisor_out;
    logic                      div_valid_out;
    logic [WIDTH-1:0]          div_quotient_in;
    logic                      div_valid_in;
    logic                      div_error_in;
    logic                      div_busy_in;

    logic [WIDTH-1:0]          pix_x_out;
    logic [WIDTH-1:0]          pix_y_out;
    logic                      pix_error_out;
    logic                      pix_valid_out;
    logic                      pix_ready_in;

    modport slave (
        input  vtx_x_in, vtx_y_in, vtx_z_in, vtx_valid_in,
        output vtx_ready_out,
        output div_dividend_out, div_divisor_out, div_valid_out,
        input  div_quotient_in, div_valid_in, div_error_in, div_busy_in,
        output pix_x_out, pix_y_out, pix_error_out, pix_valid_out,
        input  pix_ready_in
    );

    modport master (
        output vtx_x_in, vtx_y_in, vtx_z_in, vtx_valid_in,
        input  vtx_ready_out,
        input  div_dividend_out, div_divisor_out, div_valid_out,
        output div_quotient_in, div_valid_in, div_error_in, div_busy_in,
        input  pix_x_out, pix_y_out, pix_error_out, pix_valid_out,
        output pix_ready_in
    );
endinterface
`default_nettype wire

// File: rtl/perspective_divide_seq_sign_mag_split.sv
`default_nettype none
// ============================================================================
// Module   : sign_mag_split
// Purpose  : Splits a two's-complement value into sign bit and unsigned
//            magnitude.
// Ports    : i_val  - signed input
//            o_sign - 1 when i_val is negative
//            o_mag  - |i_val| as unsigned COORD_W bits
// Revision : 1.0  initial release
// ============================================================================
module sign_mag_split #(
    parameter int COORD_W = 16
) (
    input  wire logic signed [COORD_W-1:0] i_val,
    output logic                           o_sign,
    output logic        [COORD_W-1:0]      o_mag
);

    assign o_sign = i_val[COORD_W-1];
    // The most-negative value negates to itself, whose bit pattern read as
    // unsigned is exactly 2^(COORD_W-1), so no extra bit is needed.
    assign o_mag  = o_sign ? -i_val : i_val;

endmodule
`default_nettype wire

// File: rtl/perspective_divide_seq.sv
`default_nettype none
// ============================================================================
// Module   : perspective_divide_seq
// Purpose  : Sequences one vertex through a shared iterative divider:
//            (|x|<<FRAC)/|z| then (|y|<<FRAC)/|z|, restores signs and hands
//            the projected fixed-point coordinates downstream.
// Ports    : clk_in - clock
//            rst_in - asynchronous active-high reset
//            bus    - vertex in, divider link, pixel out (slave modport)
// Revision : 1.0  initial release
// ============================================================================
module perspective_divide_seq
    import proj_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int FRAC    = 8,
    parameter int WIDTH   = 32
) (
    input  wire logic                 clk_in,
    input  wire logic                 rst_in,
    perspective_divide_seq_if.slave   bus
);

    proj_state_t        r_state;
    logic               r_sx;
    logic               r_sy;
    logic [COORD_W-1:0] r_mag_x;
    logic [COORD_W-1:0] r_mag_y;
    logic [COORD_W-1:0] r_mag_z;
    logic [WIDTH-1:0]   r_pix_x;
    logic [WIDTH-1:0]   r_pix_y;
    logic               r_pix_err;
    logic               r_pix_valid;

    logic               w_sgn_x;
    logic               w_sgn_y;
    logic               w_sgn_z;
    logic [COORD_W-1:0] w_mag_x;
    logic [COORD_W-1:0] w_mag_y;
    logic [COORD_W-1:0] w_mag_z;
    logic [WIDTH-1:0]   w_ext_x;
    logic [WIDTH-1:0]   w_ext_y;
    logic [WIDTH-1:0]   w_ext_z;
    logic [WIDTH-1:0]   w_dividend;
    logic [WIDTH-1:0]   w_divisor;
    logic               w_res_sign;
    logic [WIDTH-1:0]   w_result;

    sign_mag_split #(.COORD_W(COORD_W)) u_split_x (
        .i_val (bus.vtx_x_in), .o_sign(w_sgn_x), .o_mag(w_mag_x)
    );
    sign_mag_split #(.COORD_W(COORD_W)) u_split_y (
        .i_val (bus.vtx_y_in), .o_sign(w_sgn_y), .o_mag(w_mag_y)
    );
    sign_mag_split #(.COORD_W(COORD_W)) u_split_z (
        .i_val (bus.vtx_z_in), .o_sign(w_sgn_z), .o_mag(w_mag_z)
    );

    assign w_ext_x = {{(WIDTH-COORD_W){1'b0}}, r_mag_x};
    assign w_ext_y = {{(WIDTH-COORD_W){1'b0}}, r_mag_y};
    assign w_ext_z = {{(WIDTH-COORD_W){1'b0}}, r_mag_z};

    // Operands are a pure function of state and latched magnitudes, so they
    // stay stable from the issue cycle through the whole wait.
    always_comb begin
        w_dividend = '0;
        w_divisor  = '0;
        case (r_state)
            ISSUE_X, WAIT_X: begin
                w_dividend = w_ext_x << FRAC;
                w_divisor  = w_ext_z;
            end
            ISSUE_Y, WAIT_Y: begin
                w_dividend = w_ext_y << FRAC;
                w_divisor  = w_ext_z;
            end
            default: begin
                w_dividend = '0;
                w_divisor  = '0;
            end
        endcase
    end

    // Quotient magnitude is below 2^(WIDTH-1), so negation cannot overflow.
    assign w_res_sign = (r_state == WAIT_Y) ? r_sy : r_sx;
    assign w_result   = bus.div_error_in ? '0
                      : (w_res_sign ? -bus.div_quotient_in : bus.div_quotient_in);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_sx        <= 1'b0;
            r_sy        <= 1'b0;
            r_mag_x     <= '0;
            r_mag_y     <= '0;
            r_mag_z     <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_err   <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.vtx_valid_in) begin
                        r_sx    <= w_sgn_x ^ w_sgn_z;
                        r_sy    <= w_sgn_y ^ w_sgn_z;
                        r_mag_x <= w_mag_x;
                        r_mag_y <= w_mag_y;
                        r_mag_z <= w_mag_z;
                        r_pix_x <= '0;
                        r_pix_y <= '0;
                        if (w_mag_z == '0) begin
                            // Divide by zero never reaches the divider.
                            r_pix_err   <= 1'b1;
                            r_pix_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_pix_err   <= 1'b0;
                            r_state     <= ISSUE_X;
                        end
                    end
                end
                ISSUE_X: if (!bus.div_busy_in) r_state <= WAIT_X;
                WAIT_X: begin
                    if (bus.div_valid_in) begin
                        r_pix_x <= w_result;
                        if (bus.div_error_in) r_pix_err <= 1'b1;
                        r_state <= ISSUE_Y;
                    end
                end
                ISSUE_Y: if (!bus.div_busy_in) r_state <= WAIT_Y;
                WAIT_Y: begin
                    if (bus.div_valid_in) begin
                        r_pix_y     <= w_result;
                        if (bus.div_error_in) r_pix_err <= 1'b1;
                        r_pix_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.pix_ready_in) begin
                        r_pix_valid <= 1'b0;
                        r_pix_err   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready is masked by reset so it reads 0 for the whole reset window and
    // rises on the very first IDLE cycle afterwards.
    assign bus.vtx_ready_out    = (r_state == IDLE) && !rst_in;
    // The request fires in the issue cycle itself so it follows acceptance
    // by one cycle when the divider is idle.
    assign bus.div_valid_out    = ((r_state == ISSUE_X) || (r_state == ISSUE_Y))
                                  && !bus.div_busy_in;
    assign bus.div_dividend_out = w_dividend;
    assign bus.div_divisor_out  = w_divisor;
    assign bus.pix_x_out        = r_pix_x;
    assign bus.pix_y_out        = r_pix_y;
    assign bus.pix_error_out    = r_pix_err;
    assign bus.pix_valid_out    = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_perspective_divide_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_perspective_divide_seq
// Purpose  : Self-checking bench for perspective_divide_seq with a
//            behavioural iterative-divider model and a plain-arithmetic
//            reference for the projected coordinates.
// Revision : 1.0  initial release
// ============================================================================
module tb_perspective_divide_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    perspective_divide_seq_if #(.COORD_W(16), .WIDTH(32)) bus ();

    perspective_divide_seq #(.COORD_W(16), .FRAC(8), .WIDTH(32)) u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- divider model ----------------
    int          lat_cfg      = 0;   // 0 = random 1..4 cycles
    int          err_on_pulse = -1;  // request number answered with error
    logic        force_busy   = 1'b0;
    int          pulse_cnt    = 0;
    int          stab_bad     = 0;
    logic        m_busy, m_vout, m_err, m_err_pend;
    logic [31:0] m_dvd, m_dvs, m_q;
    int          m_cnt;

    assign bus.div_busy_in     = m_busy | force_busy;
    assign bus.div_valid_in    = m_vout;
    assign bus.div_error_in    = m_err;
    assign bus.div_quotient_in = m_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_vout <= 1'b0; m_err <= 1'b0; m_err_pend <= 1'b0;
            m_q <= '0; m_cnt <= 0; m_dvd <= '0; m_dvs <= '0;
        end else begin
            m_vout <= 1'b0;
            m_err  <= 1'b0;
            if (bus.div_valid_out) begin
                pulse_cnt  <= pulse_cnt + 1;
                m_dvd      <= bus.div_dividend_out;
                m_dvs      <= bus.div_divisor_out;
                m_busy     <= 1'b1;
                m_cnt      <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
                m_err_pend <= ((pulse_cnt + 1) == err_on_pulse);
            end else if (m_busy) begin
                if (bus.div_dividend_out != m_dvd || bus.div_divisor_out != m_dvs)
                    stab_bad <= stab_bad + 1;
                if (m_cnt <= 1) begin
                    m_busy <= 1'b0;
                    m_vout <= 1'b1;
                    if (m_err_pend || m_dvs == 0) begin
                        m_err <= 1'b1;
                        m_q   <= 32'hDEAD_BEEF;
                    end else begin
                        m_q   <= m_dvd / m_dvs;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Projection from first principles: signed fixed-point quotient,
    // truncated toward zero; zero depth is an error with zero coordinates.
    function automatic void ref_model(input int x, input int y, input int z,
                                      output int ex, output int ey, output bit eerr);
        if (z == 0) begin
            ex = 0; ey = 0; eerr = 1'b1;
        end else begin
            ex = int'((longint'(x) * 256) / longint'(z));
            ey = int'((longint'(y) * 256) / longint'(z));
            eerr = 1'b0;
        end
    endfunction

    // Presents a vertex and returns at the negedge after the accepting edge.
    task automatic accept_vtx(input int x, input int y, input int z);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.vtx_x_in     = 16'(x);
        bus.vtx_y_in     = 16'(y);
        bus.vtx_z_in     = 16'(z);
        bus.vtx_valid_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.vtx_ready_out) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(negedge clk);
        bus.vtx_valid_in = 1'b0;
    endtask

    task automatic wait_result();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.pix_valid_out) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("result_timeout", 0, 1);
    endtask

    task automatic handoff();
        bus.pix_ready_in = 1'b1;
        @(negedge clk);
        bus.pix_ready_in = 1'b0;
    endtask

    task automatic check_pix(input string tag, input int ex, input int ey, input bit eerr);
        chk({tag, "_x"},   longint'(int'($signed(bus.pix_x_out))), longint'(ex));
        chk({tag, "_y"},   longint'(int'($signed(bus.pix_y_out))), longint'(ey));
        chk({tag, "_err"}, longint'(bus.pix_error_out), longint'(eerr));
    endtask

    typedef struct {
        int x; int y; int z;
        int ex; int ey; bit eerr; int epulses;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base, bad, px, py, ex, ey, rx, ry, rz;
        bit eerr;

        vecs[0] = '{100,    -50,    10,     2560,     -1280,   1'b0, 2};
        vecs[1] = '{30,     30,     -3,     -2560,    -2560,   1'b0, 2};
        vecs[2] = '{1,      -1,     3,      85,       -85,     1'b0, 2};
        vecs[3] = '{5,      7,      0,      0,        0,       1'b1, 0};
        vecs[4] = '{-32768, 32767,  1,      -8388608, 8388352, 1'b0, 2};
        vecs[5] = '{-32768, -32768, -32768, 256,      256,     1'b0, 2};
        vecs[6] = '{-7,     7,      -2,     896,      -896,    1'b0, 2};

        bus.vtx_x_in = '0; bus.vtx_y_in = '0; bus.vtx_z_in = '0;
        bus.vtx_valid_in = 1'b0;
        bus.pix_ready_in = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_ready",   longint'(bus.vtx_ready_out), 0);
        chk("rst_pvalid",  longint'(bus.pix_valid_out), 0);
        chk("rst_dvalid",  longint'(bus.div_valid_out), 0);
        chk("rst_pix_x",   longint'(bus.pix_x_out), 0);
        chk("rst_pix_err", longint'(bus.pix_error_out), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", longint'(bus.vtx_ready_out), 1);

        // ---- directed table ----
        for (int i = 0; i < 7; i++) begin
            base = pulse_cnt;
            accept_vtx(vecs[i].x, vecs[i].y, vecs[i].z);
            if (vecs[i].epulses > 0)
                chk("issue_latency", longint'(bus.div_valid_out), 1);
            wait_result();
            check_pix($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].eerr);
            chk($sformatf("vec%0d_pulses", i), longint'(pulse_cnt - base),
                longint'(vecs[i].epulses));
            handoff();
            chk($sformatf("vec%0d_released", i), longint'(bus.pix_valid_out), 0);
        end

        // ---- randomized vertices vs reference model ----
        for (int i = 0; i < 24; i++) begin
            rx = int'($urandom_range(0, 65535)) - 32768;
            ry = int'($urandom_range(0, 65535)) - 32768;
            rz = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535)) - 32768;
            if (i % 3 == 0 && rz != 0) rz = int'($urandom_range(1, 40)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
            ref_model(rx, ry, rz, ex, ey, eerr);
            accept_vtx(rx, ry, rz);
            wait_result();
            check_pix($sformatf("rand%0d", i), ex, ey, eerr);
            handoff();
        end

        // ---- DONE hold with a pending vertex ----
        accept_vtx(3, 4, 1);
        wait_result();
        px = int'($signed(bus.pix_x_out));
        py = int'($signed(bus.pix_y_out));
        chk("hold_x_value", longint'(px), 768);
        bus.vtx_x_in = 16'(5); bus.vtx_y_in = 16'(5); bus.vtx_z_in = 16'(1);
        bus.vtx_valid_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.pix_valid_out || bus.vtx_ready_out ||
                int'($signed(bus.pix_x_out)) != px || int'($signed(bus.pix_y_out)) != py)
                bad++;
        end
        chk("hold_stable", longint'(bad), 0);
        handoff();
        chk("hold_released", longint'(bus.pix_valid_out), 0);
        chk("hold_next_ready", longint'(bus.vtx_ready_out), 1);
        @(negedge clk);
        bus.vtx_valid_in = 1'b0;
        wait_result();
        check_pix("after_hold", 1280, 1280, 1'b0);
        handoff();

        // ---- divider busy stall in ISSUE_X ----
        force_busy = 1'b1;
        base = pulse_cnt;
        accept_vtx(100, -50, 10);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.div_valid_out) bad++;
            @(negedge clk);
        end
        chk("busy_no_pulse", longint'(bad), 0);
        force_busy = 1'b0;
        #1;
        chk("busy_release_pulse", longint'(bus.div_valid_out), 1);
        wait_result();
        check_pix("busy", 2560, -1280, 1'b0);
        chk("busy_pulses", longint'(pulse_cnt - base), 2);
        handoff();

        // ---- divider error on the x request ----
        err_on_pulse = pulse_cnt + 1;
        accept_vtx(10, 20, 1);
        wait_result();
        check_pix("div_err", 0, 5120, 1'b1);
        handoff();
        chk("div_err_cleared", longint'(bus.pix_error_out), 0);
        err_on_pulse = -1;

        // ---- asynchronous reset while waiting on x ----
        lat_cfg = 10;
        base = pulse_cnt;
        accept_vtx(7, 9, 3);
        for (int i = 0; i < 20 && pulse_cnt == base; i++) @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready",    longint'(bus.vtx_ready_out), 0);
        chk("arst_dividend", longint'(bus.div_dividend_out), 0);
        chk("arst_divisor",  longint'(bus.div_divisor_out), 0);
        chk("arst_pvalid",   longint'(bus.pix_valid_out), 0);
        chk("arst_dvalid",   longint'(bus.div_valid_out), 0);
        @(negedge clk);
        rst = 1'b0;
        lat_cfg = 0;
        @(negedge clk);
        chk("arst_idle_ready", longint'(bus.vtx_ready_out), 1);
        accept_vtx(64, 64, 2);
        wait_result();
        check_pix("post_rst", 8192, 8192, 1'b0);
        handoff();

        chk("operand_stable", longint'(stab_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
